// File: rtl/mtx_mem_arb.sv
// mtx_mem_arb: shares the local-RAM port between the matrix operand fetcher and load/store,
// giving the matrix side bounded priority while mtx_atomic is set.
module mtx_mem_arb #(
    parameter logic [21:0] MTX_BASE_W = 22'h3C0C00,
    parameter int unsigned MAX_RUN    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mtx_mreq,
    input  logic [9:0]  mtx_addr,
    input  logic        mtx_atomic,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [21:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [21:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        datack,
    output logic        ls_ack,
    output logic [31:0] rdata,
    output logic        gnt_mtx,
    output logic        err_spur
);
    typedef enum logic [1:0] {IDLE, BUSY_MTX, BUSY_LS} state_t;
    localparam logic [3:0] RUN_MAX = 4'(MAX_RUN);
    state_t      state_q, state_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic        mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
    logic [21:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
    logic        datack_q, datack_d, ls_ack_q, ls_ack_d;
    logic        gnt_mtx_q, gnt_mtx_d, err_spur_q, err_spur_d;
    logic        idle, pick_mtx, pick_ls, done;
    always_comb begin
        idle        = state_q == IDLE;
        // gnt_mtx_q doubles as the last owner for round-robin
        pick_mtx    = idle && mtx_mreq && (!ls_req || (mtx_atomic ? run_cnt_q < RUN_MAX : !gnt_mtx_q));
        pick_ls     = idle && ls_req && !pick_mtx;
        done        = !idle && mem_ack;
        state_d     = pick_mtx ? BUSY_MTX : pick_ls ? BUSY_LS : done ? IDLE : state_q;
        mem_req_d   = pick_mtx || pick_ls || (mem_req_q && !done);
        mem_wr_d    = pick_mtx ? 1'b0 : pick_ls ? ls_wr : mem_wr_q;
        mem_addr_d  = pick_mtx ? (MTX_BASE_W | {12'd0, mtx_addr}) : pick_ls ? ls_addr : mem_addr_q;
        mem_wdata_d = pick_ls ? ls_wdata : mem_wdata_q;
        gnt_mtx_d   = pick_mtx ? 1'b1 : pick_ls ? 1'b0 : gnt_mtx_q;
        datack_d    = done && state_q == BUSY_MTX;
        ls_ack_d    = done && state_q == BUSY_LS;
        rdata_d     = done ? mem_rdata : rdata_q;
        err_spur_d  = err_spur_q || (!mem_req_q && mem_ack);
        run_cnt_d   = (!ls_req || pick_ls) ? 4'd0 :
                      (pick_mtx && run_cnt_q != RUN_MAX) ? run_cnt_q + 4'd1 : run_cnt_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            run_cnt_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            datack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            gnt_mtx_q   <= 1'b0;
            err_spur_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            datack_q    <= datack_d;
            ls_ack_q    <= ls_ack_d;
            gnt_mtx_q   <= gnt_mtx_d;
            err_spur_q  <= err_spur_d;
        end
    end
    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign datack    = datack_q;
    assign ls_ack    = ls_ack_q;
    assign gnt_mtx   = gnt_mtx_q;
    assign err_spur  = err_spur_q;
endmodule

// File: tb/tb_mtx_mem_arb.sv
// tb_mtx_mem_arb: vector table, directed multi-cycle sequences and a random run
// checked against a transaction-level arbitration model.
module tb_mtx_mem_arb;
    localparam int MAX_RUN = 4;
    localparam logic [21:0] BASE = 22'h3C0C00;
    logic        clk = 1'b0, reset;
    logic        mtx_mreq, mtx_atomic, ls_req, ls_wr, mem_ack;
    logic [9:0]  mtx_addr;
    logic [21:0] ls_addr, mem_addr;
    logic [31:0] ls_wdata, mem_rdata, mem_wdata, rdata;
    logic        mem_req, mem_wr, datack, ls_ack, gnt_mtx, err_spur;
    int          n_cmp = 0, n_bad = 0;

    mtx_mem_arb #(.MTX_BASE_W(BASE), .MAX_RUN(MAX_RUN)) dut (
        .clk(clk), .reset(reset), .mtx_mreq(mtx_mreq), .mtx_addr(mtx_addr),
        .mtx_atomic(mtx_atomic), .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .datack(datack),
        .ls_ack(ls_ack), .rdata(rdata), .gnt_mtx(gnt_mtx), .err_spur(err_spur)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic mreq; logic [9:0] maddr; logic atomic;
        logic lreq; logic lwr; logic [21:0] laddr; logic [31:0] lwdata;
        logic ack; logic [31:0] mrdata;
        logic e_req; logic e_wr; logic [21:0] e_addr; logic [31:0] e_wdata;
        logic e_dack; logic e_lack; logic [31:0] e_rdata; logic e_gnt; logic e_err;
    } vec_t;
    localparam int NV = 10;
    vec_t tbl [NV];

    int          o_busy, o_run;
    bit          o_last_mtx, o_dack, o_lack, o_err, o_wr;
    logic [21:0] o_addr;
    logic [31:0] o_wdata, o_rdata;

    task automatic check(input string name, input logic [91:0] act, input logic [91:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [91:0] dut_vec(input bit full);
        return {mem_req, datack, ls_ack, gnt_mtx, err_spur, rdata,
                full ? {mem_wr, mem_addr, mem_wdata} : 55'd0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mtx_mreq = 0; mtx_addr = '0; mtx_atomic = 0; ls_req = 0; ls_wr = 0;
        ls_addr = '0; ls_wdata = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", dut_vec(1), 92'd0);
        reset = 0;
    endtask

    // Drives zero-wait acks and records the owner of each new grant.
    task automatic collect(input int n, output logic [15:0] seq, output int got);
        logic prev = 0;
        seq = '0;
        got = 0;
        for (int c = 0; c < 200 && got < n; c++) begin
            if (mem_req && !prev) begin
                seq[got] = gnt_mtx;
                got++;
            end
            prev = mem_req;
            mem_ack = mem_req;
            step();
        end
        mem_ack = 0;
    endtask

    task automatic model_reset();
        o_busy = 0; o_run = 0; o_last_mtx = 0; o_dack = 0; o_lack = 0; o_err = 0;
        o_wr = 0; o_addr = '0; o_wdata = '0; o_rdata = '0;
    endtask

    // Applies the arbitration rules to the inputs present at the coming edge.
    task automatic model_edge();
        int who;
        o_dack = 0;
        o_lack = 0;
        if (o_busy == 0 && mem_ack) o_err = 1;
        if (o_busy != 0) begin
            if (mem_ack) begin
                o_rdata = mem_rdata;
                if (o_busy == 1) o_dack = 1; else o_lack = 1;
                o_busy = 0;
            end
            if (!ls_req) o_run = 0;
        end else begin
            who = 0;
            if (mtx_mreq && ls_req) who = mtx_atomic ? (o_run < MAX_RUN ? 1 : 2) : (o_last_mtx ? 2 : 1);
            else if (mtx_mreq) who = 1;
            else if (ls_req) who = 2;
            if (who == 1) begin
                o_addr = BASE + 22'(mtx_addr);
                o_wr = 0;
                o_last_mtx = 1;
            end else if (who == 2) begin
                o_addr = ls_addr;
                o_wr = ls_wr;
                o_wdata = ls_wdata;
                o_last_mtx = 0;
            end
            if (!ls_req || who == 2) o_run = 0;
            else if (who == 1 && o_run < MAX_RUN) o_run++;
            o_busy = who;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq, want;
        int got;
        //            mreq addr   at lreq lwr laddr      lwdata        ack rdata        | req wr addr       wdata         dack lack rdata        gnt err
        tbl[0] = '{1, 10'h005, 0, 0, 0, 22'h0,      32'h0,        0, 32'h0,        1, 0, 22'h3C0C05, 32'h0,        0, 0, 32'h0,        1, 0};
        tbl[1] = '{0, 10'h000, 0, 0, 0, 22'h0,      32'h0,        0, 32'h0,        1, 0, 22'h3C0C05, 32'h0,        0, 0, 32'h0,        1, 0};
        tbl[2] = '{0, 10'h000, 0, 0, 0, 22'h0,      32'h0,        0, 32'h0,        1, 0, 22'h3C0C05, 32'h0,        0, 0, 32'h0,        1, 0};
        tbl[3] = '{0, 10'h000, 0, 0, 0, 22'h0,      32'h0,        1, 32'hDEADBEEF, 0, 0, 22'h0,      32'h0,        1, 0, 32'hDEADBEEF, 1, 0};
        tbl[4] = '{0, 10'h000, 0, 0, 0, 22'h0,      32'h0,        0, 32'h0,        0, 0, 22'h0,      32'h0,        0, 0, 32'hDEADBEEF, 1, 0};
        tbl[5] = '{0, 10'h000, 0, 1, 1, 22'h000100, 32'h12345678, 0, 32'h0,        1, 1, 22'h000100, 32'h12345678, 0, 0, 32'hDEADBEEF, 0, 0};
        tbl[6] = '{0, 10'h000, 0, 1, 1, 22'h000100, 32'h12345678, 1, 32'hCAFEF00D, 0, 0, 22'h0,      32'h0,        0, 1, 32'hCAFEF00D, 0, 0};
        tbl[7] = '{0, 10'h000, 0, 0, 0, 22'h0,      32'h0,        0, 32'h0,        0, 0, 22'h0,      32'h0,        0, 0, 32'hCAFEF00D, 0, 0};
        tbl[8] = '{0, 10'h000, 0, 0, 0, 22'h0,      32'h0,        1, 32'h55555555, 0, 0, 22'h0,      32'h0,        0, 0, 32'hCAFEF00D, 0, 1};
        tbl[9] = '{0, 10'h000, 0, 0, 0, 22'h0,      32'h0,        0, 32'h0,        0, 0, 22'h0,      32'h0,        0, 0, 32'hCAFEF00D, 0, 1};
        do_reset();
        for (int i = 0; i < NV; i++) begin
            mtx_mreq = tbl[i].mreq; mtx_addr = tbl[i].maddr; mtx_atomic = tbl[i].atomic;
            ls_req = tbl[i].lreq; ls_wr = tbl[i].lwr; ls_addr = tbl[i].laddr; ls_wdata = tbl[i].lwdata;
            mem_ack = tbl[i].ack; mem_rdata = tbl[i].mrdata;
            step();
            check($sformatf("vec%0d", i), dut_vec(tbl[i].e_req),
                  {tbl[i].e_req, tbl[i].e_dack, tbl[i].e_lack, tbl[i].e_gnt, tbl[i].e_err, tbl[i].e_rdata,
                   tbl[i].e_req ? {tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_wdata} : 55'd0});
        end

        do_reset();
        mtx_atomic = 1; mtx_mreq = 1; ls_req = 1;
        collect(10, seq, got);
        want = '0;
        for (int i = 0; i < 10; i++) want[i] = (i % (MAX_RUN + 1)) != MAX_RUN;
        check("starve_count", 92'(got), 92'd10);
        check("starve_seq", 92'(seq), 92'(want));

        do_reset();
        mtx_mreq = 1; ls_req = 1;
        collect(6, seq, got);
        check("rr_count", 92'(got), 92'd6);
        check("rr_seq", 92'(seq[5:0]), 92'(6'b010101));

        do_reset();
        ls_req = 1; ls_wr = 1; ls_addr = 22'h0ABCDE; ls_wdata = 32'hA5A5A5A5;
        step();
        check("midrst_busy", 92'({mem_req, mem_wr, gnt_mtx}), 92'(3'b110));
        #2 reset = 1;
        #1 check("midrst_async_zero", dut_vec(1), 92'd0);
        ls_req = 0;
        @(posedge clk);
        #1 check("midrst_hold_zero", dut_vec(1), 92'd0);
        #2 reset = 0;
        mem_ack = 1; mem_rdata = 32'h77777777;
        step();
        mem_ack = 0;
        check("midrst_spur", dut_vec(0), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 55'd0});
        step();
        check("midrst_no_ack", dut_vec(0), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 55'd0});

        do_reset();
        mtx_mreq = 1; mtx_addr = 10'h011;
        step();
        check("b2b_first", dut_vec(1), {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 22'h3C0C11, 32'h0});
        mtx_mreq = 0; mem_ack = 1; mem_rdata = 32'h0BADF00D;
        step();
        check("b2b_datack", dut_vec(0), {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0BADF00D, 55'd0});
        mtx_mreq = 1; mtx_addr = 10'h022; mem_ack = 0;
        step();
        check("b2b_second", dut_vec(1), {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0BADF00D, 1'b0, 22'h3C0C22, 32'h0});

        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            check("rand", dut_vec(o_busy != 0),
                  {o_busy != 0, o_dack, o_lack, o_last_mtx, o_err, o_rdata,
                   o_busy != 0 ? {o_wr, o_addr, o_wdata} : 55'd0});
            if (ls_ack) ls_req = 0;
            else if (!ls_req && $urandom_range(3) == 0) begin
                ls_req = 1; ls_wr = 1'($urandom_range(1));
                ls_addr = 22'($urandom); ls_wdata = $urandom;
            end
            mtx_mreq = 1'($urandom_range(1));
            mtx_addr = 10'($urandom);
            if ($urandom_range(15) == 0) mtx_atomic = ~mtx_atomic;
            mem_ack = mem_req ? ($urandom_range(2) == 0) : ($urandom_range(199) == 0);
            mem_rdata = $urandom;
            model_edge();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mtx_mem_arb.md
Name: mtx_mem_arb

Overview:
- Arbitrates the GPU local-RAM port between two requesters: the matrix-multiply operand fetcher and the GPU load/store unit.
- The operand fetcher supplies mtx_mreq, mtxaddr[2..11] and mtx_atomic. The load/store unit supplies ls_req and its address, data and write strobe.
- Generates the datack handshake back to the matrix sequencer and the ack to load/store.
- Gives the matrix sequencer bounded priority during MMULT so the load/store unit cannot starve.

Parameters:
- MTX_BASE_W, 22'h3C0C00: word address of the matrix region in local RAM. Bits [9:0] must be 0.
- MAX_RUN, 4: maximum consecutive matrix grants while ls_req is pending (range 1-15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mtx_mreq  in  1  matrix operand request; level signal.
- mtx_addr  in  10  matrix word address (byte address bits 11:2).
- mtx_atomic  in  1  matrix op in progress; enables matrix priority.
- ls_req  in  1  load/store request; level, held until ls_ack.
- ls_wr  in  1  1 = write, 0 = read.
- ls_addr  in  22  load/store word address.
- ls_wdata  in  32  write data.
- mem_req  out  1  RAM access request; registered.
- mem_wr  out  1  RAM write strobe; registered.
- mem_addr  out  22  RAM word address; registered.
- mem_wdata  out  32  RAM write data; registered.
- mem_ack  in  1  single-cycle completion from RAM.
- mem_rdata  in  32  RAM read data, valid with mem_ack.
- datack  out  1  one-cycle ack to the matrix sequencer.
- ls_ack  out  1  one-cycle ack to load/store.
- rdata  out  32  captured read data, valid with datack or ls_ack.
- gnt_mtx  out  1  current or last owner is the matrix requester.
- err_spur  out  1  sticky flag: mem_ack seen while idle.

Behaviour:
- Reset (asynchronous, any time including mid-access):
  - state IDLE; all outputs 0; run_cnt 0; last owner = LS.
  - An in-flight RAM access is abandoned; a mem_ack that follows is treated as spurious.
- States:
  - IDLE: arbitrate on every edge.
  - BUSY_MTX and BUSY_LS: wait for mem_ack.
- Arbitration at an IDLE edge:
  - Only mtx_mreq high: grant MTX.
  - Only ls_req high: grant LS.
  - Both high:
    - mtx_atomic=1 and run_cnt<MAX_RUN: grant MTX.
    - mtx_atomic=1 and run_cnt==MAX_RUN: grant LS.
    - mtx_atomic=0: round-robin; grant the requester that is not the last owner.
- On grant edge:
  - mem_req=1 from the next cycle.
  - MTX grant: mem_addr = MTX_BASE_W | mtx_addr; mem_wr=0 (matrix accesses are read-only); mem_wdata keeps its previous value.
  - LS grant: mem_addr = ls_addr; mem_wr = ls_wr; mem_wdata = ls_wdata.
  - gnt_mtx updated.
  - Address and data are held stable until completion; requester inputs are ignored while BUSY.
- run_cnt:
  - Increments on each MTX grant while ls_req=1, saturating at MAX_RUN.
  - Clears on an LS grant, or at any edge where ls_req=0.
- Completion (edge with mem_ack=1 in a BUSY state):
  - Next cycle: mem_req=0, state IDLE, rdata=mem_rdata (also on writes).
  - One-cycle pulse: datack=1 if BUSY_MTX, ls_ack=1 if BUSY_LS.
- Throughput and latency:
  - The ack cycle is an IDLE cycle, so a request high during it is arbitrated at that cycle's edge.
  - This holds for the matrix sequencer, whose mtx_mreq during datack reflects only a new request.
  - Minimum spacing between grants to the same requester is 2 cycles plus RAM latency.
  - Request to mem_req latency is 1 cycle; mem_ack to ack latency is 1 cycle.
- mem_ack with mem_req=0:
  - Ignored: no ack, no rdata update.
  - err_spur sets and stays set until reset.
- mem_ack in the same cycle mem_req first rises is legal (zero-wait RAM).

Test Plan:
- Single MTX read: mtx_mreq=1, mtx_addr=10'h005, RAM acks 2 cycles after mem_req rises with rdata 32'hDEADBEEF.
  - Expect: mem_req high cycles 1-3, mem_addr=22'h3C0C05, mem_wr=0, datack pulse cycle 4, rdata=DEADBEEF.
- LS write: ls_req=1, ls_wr=1, ls_addr=22'h000100, ls_wdata=32'h12345678, zero-wait ack.
  - Expect: mem_wr=1 with the given addr/data, ls_ack one cycle after mem_ack, ls_ack never high for two consecutive cycles.
- Starvation bound: mtx_atomic=1, mtx_mreq and ls_req held high, MAX_RUN=4.
  - Expect grant sequence MTX,MTX,MTX,MTX,LS,MTX..., and run_cnt returns to 0 after the LS grant.
- Round-robin: mtx_atomic=0, both requests high continuously.
  - Expect alternating MTX,LS,MTX,... starting with MTX after reset.
- Reset mid-access: assert reset while BUSY_LS, release, then RAM asserts mem_ack.
  - Expect: all outputs 0 during reset, no ls_ack, err_spur=1.
- Back-to-back: matrix requester re-raises mtx_mreq during the datack cycle.
  - Expect mem_req high again the next cycle with the new address.
